mem_rd_scheduler: RTL and testbench

Round-robin scheduler that shares one memory read channel between NREQ requesters. It runs the classic wait-stated read sequence (rd strobe, stretch while ws, ds data strobe) on behalf of the granted requester. It returns a one-cycle done pulse to that requester. It sits between client blocks and the memory read port, replacing a single-master go-triggered read FSM.

---
 rtl/mem_rd_scheduler.sv | 139 +++++++++++++
 tb/tb_mem_rd_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_scheduler.sv
// Round-robin scheduler sharing one wait-stated memory read channel between NREQ requesters.
// Optional WS_TIMEOUT_EN: abort a read after TIMEOUT consecutive ws-high cycles in DLY.
module mem_rd_scheduler #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr_in,
  input  logic                   ws,
  output logic                   rd,
  output logic                   ds,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("mem_rd_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, READ, DLY, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     cur;
  logic [PW-1:0]     nxt_ptr;
  logic [PW-1:0]     win_idx;
  logic              win_vld;
  logic [NREQ-1:0]   win_gnt;
  logic [ADDR_W-1:0] win_addr;
  logic [PW:0]       probe;

  // Winner is the first set req bit at or above rr_ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    probe    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      probe = {1'b0, rr_ptr} + (PW+1)'(k);
      if (probe >= (PW+1)'(NREQ))
        probe = probe - (PW+1)'(NREQ);
      if (!win_vld && req[probe[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = probe[PW-1:0];
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == PW'(k))
        win_addr = addr_in[k*ADDR_W +: ADDR_W];
    end
    win_gnt = NREQ'(1) << win_idx;
  end

  assign nxt_ptr = (cur == PW'(NREQ-1)) ? '0 : cur + PW'(1);

`ifdef WS_TIMEOUT_EN
  logic [7:0] ws_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd       <= 1'b0;
      ds       <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      mem_addr <= '0;
      rr_ptr   <= '0;
      cur      <= '0;
`ifdef WS_TIMEOUT_EN
      err      <= 1'b0;
      ws_cnt   <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= READ;
            gnt      <= win_gnt;
            mem_addr <= win_addr;
            cur      <= win_idx;
            rd       <= 1'b1;
            busy     <= 1'b1;
          end
        end
        READ: begin
          state <= DLY;
`ifdef WS_TIMEOUT_EN
          ws_cnt <= '0;
`endif
        end
        DLY: begin
          if (!ws) begin
            state  <= DONE;
            rd     <= 1'b0;
            ds     <= 1'b1;
            done   <= gnt;
            rr_ptr <= nxt_ptr;
          end
`ifdef WS_TIMEOUT_EN
          // This ws-high cycle is the TIMEOUT-th one: abort instead of waiting further.
          else if (ws_cnt == 8'(TIMEOUT-1)) begin
            state  <= DONE;
            rd     <= 1'b0;
            err    <= 1'b1;
            done   <= gnt;
            rr_ptr <= nxt_ptr;
          end else begin
            ws_cnt <= ws_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          ds    <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
`ifdef WS_TIMEOUT_EN
          err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_scheduler.sv
// Randomized self-checking bench for mem_rd_scheduler using a transaction-level timeline model.
`timescale 1ns/1ps
module tb_mem_rd_scheduler;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
`ifdef WS_TIMEOUT_EN
  localparam int TO    = 3;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 15;
  localparam bit TO_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] addr_in;
  logic                   ws;
  logic                   rd, ds, busy, err;
  logic [ADDR_W-1:0]      mem_addr;
  logic [NREQ-1:0]        gnt, done;

  logic [ADDR_W-1:0] addrs [NREQ];
  int ptr;
  int n_checks = 0;
  int n_errors = 0;
  int w;

  always #5 clk = ~clk;

  mem_rd_scheduler #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .ws(ws),
    .rd(rd), .ds(ds), .mem_addr(mem_addr), .gnt(gnt), .done(done),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < NREQ; i++) addr_in[i*ADDR_W +: ADDR_W] = addrs[i];
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_rd"},   32'(rd),   32'(0));
    check({tag, "_ds"},   32'(ds),   32'(0));
    check({tag, "_gnt"},  32'(gnt),  32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_err"},  32'(err),  32'(0));
  endtask

  // One transaction from an IDLE cycle: grant, READ, d ws-high DLY cycles, DONE, back to IDLE.
  task automatic run_txn(input logic [NREQ-1:0] r, input int d, input bit drop, output int win);
    logic [NREQ-1:0]   oh;
    logic [ADDR_W-1:0] ea;
    bit                ab;
    drive_addrs();
    req = r;
    ws  = 1'($urandom);
    win = pick(r, ptr);
    tick();
    if (win < 0) begin
      check_idle("noreq");
      return;
    end
    oh = NREQ'(1) << win;
    ea = addrs[win];
    check("read_gnt",  32'(gnt),      32'(oh));
    check("read_rd",   32'(rd),       32'(1));
    check("read_ds",   32'(ds),       32'(0));
    check("read_busy", 32'(busy),     32'(1));
    check("read_addr", 32'(mem_addr), 32'(ea));
    if (drop) begin
      req[win]   = 1'b0;
      addrs[win] = ~ea;
      drive_addrs();
    end
    ws = 1'($urandom);
    tick();
    check("dly_rd",   32'(rd),       32'(1));
    check("dly_gnt",  32'(gnt),      32'(oh));
    check("dly_addr", 32'(mem_addr), 32'(ea));
    ab = 1'b0;
    for (int i = 0; i < d; i++) begin
      ws = 1'b1;
      tick();
      if (TO_EN && i + 1 == TO) begin
        ab = 1'b1;
        break;
      end
      check("wait_rd",   32'(rd),   32'(1));
      check("wait_ds",   32'(ds),   32'(0));
      check("wait_done", 32'(done), 32'(0));
    end
    if (!ab) begin
      ws = 1'b0;
      tick();
    end
    check("done_rd",   32'(rd),       32'(0));
    check("done_ds",   32'(ds),       32'(!ab));
    check("done_done", 32'(done),     32'(oh));
    check("done_gnt",  32'(gnt),      32'(oh));
    check("done_busy", 32'(busy),     32'(1));
    check("done_err",  32'(err),      32'(ab));
    check("done_addr", 32'(mem_addr), 32'(ea));
    ptr = (win + 1) % NREQ;
    ws  = 1'($urandom);
    tick();
    check_idle("post");
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    for (int i = 0; i < NREQ; i++) addrs[i] = ADDR_W'($urandom);
    drive_addrs();
    tick();
    tick();
    check_idle("reset");
    check("reset_addr", 32'(mem_addr), 32'(0));
    rst = 1'b0;
    ptr = 0;

    // All requesters held high: strict rotation from rr_ptr=0.
    for (int k = 0; k < 5; k++) begin
      run_txn('1, 0, 1'b0, w);
      check("rr_order", 32'(w), 32'(k % NREQ));
    end

    addrs[0] = 8'h3C;
    run_txn(4'b0001, 0, 1'b0, w);
    run_txn(4'b0001, 5, 1'b0, w);
    run_txn(4'b0100, 1, 1'b1, w);
    check("drop_win", 32'(w), 32'(2));

    // Reset in DLY with rr_ptr=3, then a pattern whose winner depends on rr_ptr.
    run_txn(4'b0100, 0, 1'b0, w);
    req = 4'b1000;
    ws  = 1'b1;
    tick();
    check("pre_rst_gnt", 32'(gnt), 32'(4'b1000));
    tick();
    tick();
    check("pre_rst_rd", 32'(rd), 32'(1));
    rst = 1'b1;
    tick();
    check_idle("midrst");
    check("midrst_addr", 32'(mem_addr), 32'(0));
    rst = 1'b0;
    req = '0;
    ptr = 0;
    tick();
    check_idle("midrst_idle");
    run_txn(4'b1100, 0, 1'b0, w);
    check("rst_ptr_win", 32'(w), 32'(2));
    run_txn(4'b0100, 0, 1'b0, w);
    check("rst_req2_win", 32'(w), 32'(2));

    run_txn(4'b0010, 8, 1'b0, w);
    run_txn(4'b0001, 0, 1'b0, w);

    for (int t = 0; t < 80; t++) begin
      logic [NREQ-1:0] r;
      for (int i = 0; i < NREQ; i++) addrs[i] = ADDR_W'($urandom);
      r = NREQ'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      run_txn(r, int'($urandom_range(0, 5)), $urandom_range(0, 3) == 0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
